alu16_sequencer: RTL and testbench

//  Upstream sequencer for the 8-bit ALU. Runs 16-bit ops (ADD HL,rr; ADD SP,e8 / LD HL,SP+e8; INC rr; DEC rr)
//  as two byte passes, low then high. It drives ALU operand1, operand2 and carry-in, and chains the low-pass carry

---
 rtl/alu16_pkg.sv | 25 ++
 rtl/alu16_flag_gen.sv | 45 ++++
 rtl/alu16_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_alu16_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// Shared encodings for the 16-bit two-pass ALU sequencer.
package alu16_pkg;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'b00,
    OP_ADDSP = 2'b01,
    OP_INC16 = 2'b10,
    OP_DEC16 = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LO_REQ  = 3'd1,
    S_LO_WAIT = 3'd2,
    S_HI_REQ  = 3'd3,
    S_HI_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int FW_Z = 3;
  localparam int FW_N = 2;
  localparam int FW_H = 1;
  localparam int FW_C = 0;

endpackage

// File: rtl/alu16_flag_gen.sv
// Combinational flag values and write enables for a completed 16-bit op.
module alu16_flag_gen
  import alu16_pkg::*;
(
  input  logic [1:0] op,
  input  logic       lo_hout,
  input  logic       lo_cout,
  input  logic       hi_hout,
  input  logic       hi_cout,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c,
  output logic [3:0] flag_we
);

  always_comb begin
    flag_z  = 1'b0;
    flag_n  = 1'b0;
    flag_h  = 1'b0;
    flag_c  = 1'b0;
    flag_we = 4'b0000;
    case (op_t'(op))
      OP_ADD16: begin
        // Z is left untouched by 16-bit register adds; H/C come from bits 11/15.
        flag_h        = hi_hout;
        flag_c        = hi_cout;
        flag_we[FW_N] = 1'b1;
        flag_we[FW_H] = 1'b1;
        flag_we[FW_C] = 1'b1;
      end
      OP_ADDSP: begin
        // SP-relative adds report carries from the low byte (bits 3/7).
        flag_h        = lo_hout;
        flag_c        = lo_cout;
        flag_we[FW_Z] = 1'b1;
        flag_we[FW_N] = 1'b1;
        flag_we[FW_H] = 1'b1;
        flag_we[FW_C] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu16_sequencer.sv
// Sequences 16-bit ADD/ADDSP/INC/DEC through an 8-bit ALU as a low pass then a
// carry-chained high pass, then presents the result and flag update for one cycle.
module alu16_sequencer
  import alu16_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [15:0] res,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_h,
  output logic        flag_c,
  output logic [3:0]  flag_we,
  output logic        alu_req,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_res,
  input  logic        alu_cout,
  input  logic        alu_hout
);

  localparam bit         HAS_WAIT  = (ALU_LAT > 0);
  localparam logic [1:0] WAIT_LOAD = HAS_WAIT ? 2'(ALU_LAT - 1) : 2'd0;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        lo_cap, hi_cap;

  logic [1:0]  op_q;
  logic [15:0] opa_q, opb_q;
  logic [7:0]  lo_res_q;
  logic        lo_cout_q, lo_hout_q;

  logic [15:0] res_q;
  logic        z_q, n_q, h_q, c_q;
  logic [3:0]  we_q;

  logic        gen_z, gen_n, gen_h, gen_c;
  logic [3:0]  gen_we;
  logic [7:0]  lo_b, hi_b;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The wait states count down from ALU_LAT-1; the terminal count is the capture cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_cap  = 1'b0;
    hi_cap  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LO_REQ;
      S_LO_REQ: begin
        if (HAS_WAIT) begin
          state_d = S_LO_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          lo_cap  = 1'b1;
          state_d = S_HI_REQ;
        end
      end
      S_LO_WAIT: begin
        if (cnt_q == 2'd0) begin
          lo_cap  = 1'b1;
          state_d = S_HI_REQ;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_HI_REQ: begin
        if (HAS_WAIT) begin
          state_d = S_HI_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          hi_cap  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_HI_WAIT: begin
        if (cnt_q == 2'd0) begin
          hi_cap  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      lo_cap  = 1'b0;
      hi_cap  = 1'b0;
    end
  end

  always_comb begin
    lo_b = opb_q[7:0];
    hi_b = opb_q[15:8];
    case (op_t'(op_q))
      OP_ADD16: begin
        lo_b = opb_q[7:0];
        hi_b = opb_q[15:8];
      end
      OP_ADDSP: begin
        lo_b = opb_q[7:0];
        hi_b = {8{opb_q[7]}};
      end
      OP_INC16: begin
        lo_b = 8'h01;
        hi_b = 8'h00;
      end
      OP_DEC16: begin
        lo_b = 8'hFF;
        hi_b = 8'hFF;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_req = 1'b0;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cin = 1'b0;
    case (state_q)
      S_LO_REQ, S_LO_WAIT: begin
        alu_req = (state_q == S_LO_REQ);
        alu_a   = opa_q[7:0];
        alu_b   = lo_b;
      end
      S_HI_REQ, S_HI_WAIT: begin
        alu_req = (state_q == S_HI_REQ);
        alu_a   = opa_q[15:8];
        alu_b   = hi_b;
        alu_cin = lo_cout_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      op_q      <= 2'b00;
      opa_q     <= 16'h0000;
      opb_q     <= 16'h0000;
      lo_res_q  <= 8'h00;
      lo_cout_q <= 1'b0;
      lo_hout_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        op_q  <= op;
        opa_q <= opa;
        opb_q <= opb;
      end
      if (lo_cap) begin
        lo_res_q  <= alu_res;
        lo_cout_q <= alu_cout;
        lo_hout_q <= alu_hout;
      end
    end
  end

  alu16_flag_gen u_flag_gen (
    .op      (op_q),
    .lo_hout (lo_hout_q),
    .lo_cout (lo_cout_q),
    .hi_hout (alu_hout),
    .hi_cout (alu_cout),
    .flag_z  (gen_z),
    .flag_n  (gen_n),
    .flag_h  (gen_h),
    .flag_c  (gen_c),
    .flag_we (gen_we)
  );

  // The high byte is folded straight into res on the capture edge so res is valid in DONE.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      res_q <= 16'h0000;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      h_q   <= 1'b0;
      c_q   <= 1'b0;
      we_q  <= 4'b0000;
    end else if (hi_cap) begin
      res_q <= {alu_res, lo_res_q};
      z_q   <= gen_z;
      n_q   <= gen_n;
      h_q   <= gen_h;
      c_q   <= gen_c;
      we_q  <= gen_we;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign res     = res_q;
  assign flag_z  = z_q;
  assign flag_n  = n_q;
  assign flag_h  = h_q;
  assign flag_c  = c_q;
  assign flag_we = (state_q == S_DONE) ? we_q : 4'b0000;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench: two sequencers (ALU_LAT=1 and ALU_LAT=0), each with an adder ALU model.
module tb_alu16_sequencer;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic [1:0]  op_s = 2'b00;
  logic [15:0] opa_s = 16'h0000, opb_s = 16'h0000;
  logic        flush = 1'b0;

  logic        busy1, done1, z1, n1, h1, c1, req1, cin1;
  logic [15:0] res1;
  logic [3:0]  we1;
  logic [7:0]  a1, b1;
  logic [9:0]  m1;

  logic        busy0, done0, z0, n0, h0, c0, req0, cin0;
  logic [15:0] res0;
  logic [3:0]  we0;
  logic [7:0]  a0, b0;
  logic [9:0]  m0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // {hout, cout, sum}
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] s;
    logic [4:0] l;
    s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    l = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
    return {l[4], s[8], s[7:0]};
  endfunction

  always @(posedge clk) m1 <= alu_f(a1, b1, cin1);
  assign m0 = alu_f(a0, b0, cin0);

  alu16_sequencer #(.ALU_LAT(1)) u_lat1 (
    .CLK(clk), .nRESET(nreset), .start(start1), .op(op_s), .opa(opa_s), .opb(opb_s),
    .flush(flush), .busy(busy1), .done(done1), .res(res1),
    .flag_z(z1), .flag_n(n1), .flag_h(h1), .flag_c(c1), .flag_we(we1),
    .alu_req(req1), .alu_a(a1), .alu_b(b1), .alu_cin(cin1),
    .alu_res(m1[7:0]), .alu_cout(m1[8]), .alu_hout(m1[9])
  );

  alu16_sequencer #(.ALU_LAT(0)) u_lat0 (
    .CLK(clk), .nRESET(nreset), .start(start0), .op(op_s), .opa(opa_s), .opb(opb_s),
    .flush(flush), .busy(busy0), .done(done0), .res(res0),
    .flag_z(z0), .flag_n(n0), .flag_h(h0), .flag_c(c0), .flag_we(we0),
    .alu_req(req0), .alu_a(a0), .alu_b(b0), .alu_cin(cin0),
    .alu_res(m0[7:0]), .alu_cout(m0[8]), .alu_hout(m0[9])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op on the selected instance; report start-to-done latency (0 = timed out).
  task automatic run(input bit sel, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                     output int lat, output logic [15:0] r, output logic [3:0] fl,
                     output logic [3:0] we, output logic [7:0] hib);
    int nreq;
    lat = 0; nreq = 0; hib = 8'h00; r = 16'h0000; fl = 4'h0; we = 4'h0;
    @(negedge clk);
    op_s = o; opa_s = a; opb_s = b;
    if (sel) start0 = 1'b1; else start1 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if (sel ? req0 : req1) begin
        nreq++;
        if (nreq == 2) hib = sel ? b0 : b1;
      end
      if (sel ? done0 : done1) begin
        lat = n;
        r   = sel ? res0 : res1;
        fl  = sel ? {z0, n0, h0, c0} : {z1, n1, h1, c1};
        we  = sel ? we0 : we1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [15:0] r;
    logic [3:0] fl, we;
    logic [7:0] hib;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_res", {16'd0, res1}, 32'd0);
    chk("rst_we", {28'd0, we1}, 32'd0);
    chk("rst_req", {31'd0, req1}, 32'd0);
    nreset = 1'b1;

    run(0, 2'b00, 16'h0FFF, 16'h0001, lat, r, fl, we, hib);
    chk("add16_lat", lat, 5);
    chk("add16_res", {16'd0, r}, 32'h1000);
    chk("add16_flags", {28'd0, fl}, 32'b0010);
    chk("add16_we", {28'd0, we}, 32'b0111);
    @(negedge clk);
    chk("we_after_done", {28'd0, we1}, 32'd0);

    run(0, 2'b00, 16'hFFFF, 16'h0001, lat, r, fl, we, hib);
    chk("add16_wrap_res", {16'd0, r}, 32'h0000);
    chk("add16_wrap_flags", {28'd0, fl}, 32'b0011);
    chk("add16_wrap_we", {28'd0, we}, 32'b0111);

    run(1, 2'b00, 16'hFFFF, 16'h0001, lat, r, fl, we, hib);
    chk("lat0_lat", lat, 3);
    chk("lat0_res", {16'd0, r}, 32'h0000);
    chk("lat0_flags", {28'd0, fl}, 32'b0011);

    run(0, 2'b01, 16'h00FF, 16'h0001, lat, r, fl, we, hib);
    chk("addsp_res", {16'd0, r}, 32'h0100);
    chk("addsp_flags", {28'd0, fl}, 32'b0011);
    chk("addsp_we", {28'd0, we}, 32'b1111);

    run(0, 2'b01, 16'h0000, 16'h00FF, lat, r, fl, we, hib);
    chk("addsp_neg_res", {16'd0, r}, 32'hFFFF);
    chk("addsp_neg_flags", {28'd0, fl}, 32'b0000);
    chk("addsp_neg_hib", {24'd0, hib}, 32'hFF);

    run(0, 2'b10, 16'hFFFF, 16'h5A5A, lat, r, fl, we, hib);
    chk("inc_res", {16'd0, r}, 32'h0000);
    chk("inc_we", {28'd0, we}, 32'b0000);
    chk("inc_hib", {24'd0, hib}, 32'h00);
    chk("inc_flags", {28'd0, fl}, 32'b0000);

    run(0, 2'b11, 16'h0000, 16'h0000, lat, r, fl, we, hib);
    chk("dec_res", {16'd0, r}, 32'hFFFF);
    chk("dec_we", {28'd0, we}, 32'b0000);
    chk("dec_hib", {24'd0, hib}, 32'hFF);

    run(0, 2'b11, 16'h1234, 16'h0000, lat, r, fl, we, hib);
    chk("dec_borrow_res", {16'd0, r}, 32'h1233);

    // start pulsed mid-op must not disturb latched operands
    @(negedge clk);
    op_s = 2'b00; opa_s = 16'h0100; opb_s = 16'h0001; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk); start1 = 1'b1; opa_s = 16'hFFFF;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_start_done", {31'd0, done1}, 32'd1);
    chk("busy_start_res", {16'd0, res1}, 32'h0101);

    // flush in HI_WAIT
    @(negedge clk);
    op_s = 2'b00; opa_s = 16'h2222; opb_s = 16'h1111; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", {31'd0, busy1}, 32'd0);
    chk("flush_done", {31'd0, done1}, 32'd0);
    chk("flush_res", {16'd0, res1}, 32'h0101);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= done1;
    end
    chk("flush_no_done", {31'd0, seen}, 32'd0);

    // async reset during LO_WAIT
    op_s = 2'b00; opa_s = 16'h12AB; opb_s = 16'h0000; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    chk("pre_rst_alu_a", {24'd0, a1}, 32'hAB);
    nreset = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy1}, 32'd0);
    chk("rst_mid_req", {31'd0, req1}, 32'd0);
    chk("rst_mid_res", {16'd0, res1}, 32'd0);
    chk("rst_mid_alu_a", {24'd0, a1}, 32'd0);
    @(negedge clk); nreset = 1'b1;

    run(0, 2'b00, 16'h1234, 16'h1111, lat, r, fl, we, hib);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_res", {16'd0, r}, 32'h2345);
    chk("post_rst_flags", {28'd0, fl}, 32'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
